// File: rtl/cfu_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfu_bank_pkg
// Description : Shared constants and types for the scratchpad bank writer
//               CFU: op encodings, FSM state type, bank geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package cfu_bank_pkg;

  // Bank geometry. A pointer is {bank, word address}.
  localparam int ADDR_W    = 14;
  localparam int BANK_W    = 2;
  localparam int NUM_BANKS = 4;
  localparam int PTR_W     = BANK_W + ADDR_W;
  localparam int CNT_W     = 16;

  // Operation select, function_id[2:0]
  localparam logic [2:0] OP_WRITE   = 3'd0;
  localparam logic [2:0] OP_SET_PTR = 3'd1;
  localparam logic [2:0] OP_STREAM  = 3'd2;
  localparam logic [2:0] OP_FILL    = 3'd3;
  localparam logic [2:0] OP_STATUS  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bank_wr_decode.sv
`default_nettype none
// ============================================================================
// Module      : bank_wr_decode
// Description : Registers one write request and decodes its bank field into
//               a one-hot write strobe. Address and data are shared by all
//               banks and hold their last value between writes.
// Ports       : clk, reset (async, active-low)
//               wr_valid/wr_bank/wr_addr/wr_data - request for this cycle
//               bank_addr/bank_dout               - registered broadcast
//               bank_wen                          - registered one-hot strobe
// Revision    : 1.0 - initial release
// ============================================================================
module bank_wr_decode #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_valid,
  input  logic [cfu_bank_pkg::BANK_W-1:0]     wr_bank,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [DATA_W-1:0]                   wr_data,
  output logic [ADDR_W-1:0]                   bank_addr,
  output logic [DATA_W-1:0]                   bank_dout,
  output logic [cfu_bank_pkg::NUM_BANKS-1:0]  bank_wen
);
  import cfu_bank_pkg::*;

  logic [NUM_BANKS-1:0] w_wen_dec;
  logic [NUM_BANKS-1:0] r_wen;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_dout;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_dec
    assign w_wen_dec[b] = wr_valid && (wr_bank == BANK_W'(b));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wen  <= '0;
      r_addr <= '0;
      r_dout <= '0;
    end else begin
      r_wen <= w_wen_dec;
      // Address/data only move on a write so idle cycles do not toggle the banks.
      if (wr_valid) begin
        r_addr <= wr_addr;
        r_dout <= wr_data;
      end
    end
  end

  assign bank_addr = r_addr;
  assign bank_dout = r_dout;
  assign bank_wen  = r_wen;

endmodule
`default_nettype wire

// File: rtl/cfu_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : cfu_bank_writer
// Description : CFU that writes the four 32-bit scratchpad banks. Supports
//               single writes, pointer streaming, multi-cycle fills and a
//               status readback of {write count, pointer}.
// Ports       : clk, reset (async, active-low)
//               cmd_*  - CFU command handshake (function_id[2:0] = op)
//               rsp_*  - CFU response handshake, held until rsp_ready
//               portN_addr/dout/wen - bank write ports, N = 0..3
// Revision    : 1.0 - initial release
// ============================================================================
module cfu_bank_writer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [31:0]       cmd_payload_inputs_0,
  input  logic [31:0]       cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_payload_outputs_0,
  output logic [ADDR_W-1:0] port0_addr,
  output logic [DATA_W-1:0] port0_dout,
  output logic              port0_wen,
  output logic [ADDR_W-1:0] port1_addr,
  output logic [DATA_W-1:0] port1_dout,
  output logic              port1_wen,
  output logic [ADDR_W-1:0] port2_addr,
  output logic [DATA_W-1:0] port2_dout,
  output logic              port2_wen,
  output logic [ADDR_W-1:0] port3_addr,
  output logic [DATA_W-1:0] port3_dout,
  output logic              port3_wen
);
  import cfu_bank_pkg::*;

  state_e             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]   r_fill_rem;   // fill writes still to issue after the current one
  logic [DATA_W-1:0]  r_fill_data;
  logic [31:0]        r_rsp_payload;

  logic [2:0]         w_op;
  logic [CNT_W-1:0]   w_count;
  logic               w_accept;
  logic               w_fill_start;
  logic               w_wr_valid;
  logic [PTR_W-1:0]   w_wr_loc;
  logic [DATA_W-1:0]  w_wr_data;
  logic [PTR_W-1:0]   w_ptr_inc;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [31:0]        w_rsp_next;
  logic [ADDR_W-1:0]  w_bank_addr;
  logic [DATA_W-1:0]  w_bank_dout;
  logic [NUM_BANKS-1:0] w_bank_wen;
  logic               w_unused;

  assign w_op     = cmd_payload_function_id[2:0];
  assign w_count  = cmd_payload_inputs_1[CNT_W-1:0];
  assign w_unused = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[31:16]};

  // A response being consumed frees the unit in the same cycle.
  assign cmd_ready = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_fill_start = w_accept && (w_op == OP_FILL) && (w_count != '0);

  // 16-bit modulo increment: the address carries into the bank field.
  assign w_ptr_inc = r_ptr + PTR_W'(1);

  // Write request for this cycle; registered by the decoder, so it strobes next cycle.
  always_comb begin
    w_wr_valid = 1'b0;
    w_wr_loc   = r_ptr;
    w_wr_data  = r_fill_data;
    if (r_state == ST_FILL) begin
      w_wr_valid = (r_fill_rem != '0);
    end else if (w_accept) begin
      case (w_op)
        OP_WRITE: begin
          w_wr_valid = 1'b1;
          w_wr_loc   = cmd_payload_inputs_1[PTR_W-1:0];
          w_wr_data  = cmd_payload_inputs_0;
        end
        OP_STREAM: begin
          w_wr_valid = 1'b1;
          w_wr_data  = cmd_payload_inputs_0;
        end
        OP_FILL: begin
          w_wr_valid = (w_count != '0);
          w_wr_data  = cmd_payload_inputs_0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    w_rsp_next = 32'd0;
    case (w_op)
      OP_WRITE:   w_rsp_next = {16'd0, cmd_payload_inputs_1[15:0]};
      OP_SET_PTR: begin
        w_ptr_next = cmd_payload_inputs_1[PTR_W-1:0];
        w_rsp_next = {16'd0, r_ptr};
      end
      OP_STREAM: begin
        w_ptr_next = w_ptr_inc;
        w_rsp_next = {16'd0, w_ptr_inc};
      end
      OP_FILL: begin
        if (w_count != '0) w_ptr_next = w_ptr_inc;
        w_rsp_next = {16'd0, w_count};
      end
      OP_STATUS:  w_rsp_next = {r_wcnt, r_ptr};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_wcnt        <= '0;
      r_fill_rem    <= '0;
      r_fill_data   <= '0;
      r_rsp_payload <= '0;
    end else begin
      // Counted when issued so the count is visible in the strobe cycle.
      if (w_wr_valid && (r_wcnt != '1)) r_wcnt <= r_wcnt + CNT_W'(1);

      case (r_state)
        ST_FILL: begin
          // The extra cycle with nothing left to issue places rsp_valid one
          // cycle after the last strobe.
          if (r_fill_rem == '0) begin
            r_state <= ST_RESP;
          end else begin
            r_fill_rem <= r_fill_rem - CNT_W'(1);
            r_ptr      <= w_ptr_inc;
          end
        end
        default: begin
          if (w_accept) begin
            r_ptr         <= w_ptr_next;
            r_rsp_payload <= w_rsp_next;
            if (w_fill_start) begin
              r_state     <= ST_FILL;
              r_fill_rem  <= w_count - CNT_W'(1);
              r_fill_data <= cmd_payload_inputs_0;
            end else begin
              r_state <= ST_RESP;
            end
          end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign rsp_valid             = (r_state == ST_RESP);
  assign rsp_payload_outputs_0 = r_rsp_payload;

  bank_wr_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_decode (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (w_wr_valid),
    .wr_bank   (w_wr_loc[PTR_W-1 -: BANK_W]),
    .wr_addr   (w_wr_loc[ADDR_W-1:0]),
    .wr_data   (w_wr_data),
    .bank_addr (w_bank_addr),
    .bank_dout (w_bank_dout),
    .bank_wen  (w_bank_wen)
  );

  assign port0_addr = w_bank_addr;
  assign port1_addr = w_bank_addr;
  assign port2_addr = w_bank_addr;
  assign port3_addr = w_bank_addr;
  assign port0_dout = w_bank_dout;
  assign port1_dout = w_bank_dout;
  assign port2_dout = w_bank_dout;
  assign port3_dout = w_bank_dout;
  assign port0_wen  = w_bank_wen[0];
  assign port1_wen  = w_bank_wen[1];
  assign port2_wen  = w_bank_wen[2];
  assign port3_wen  = w_bank_wen[3];

endmodule
`default_nettype wire

// File: doc/cfu_bank_writer.md
# cfu_bank_writer

Custom function unit that writes into the four 32-bit scratchpad banks, complementing the single-cycle bank read CFU. It accepts CPU commands over the standard CFU cmd/rsp handshake. It performs single writes, pointer-based streaming writes, and multi-cycle fills. Each cycle it drives at most one write-enabled bank, with address and data broadcast to all four banks.

## Interface

- ADDR_W, 14, bank word-address width
- DATA_W, 32, bank word width

- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (low = in reset)
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_payload_function_id  input  10  bits [2:0] select op; [9:3] ignored
- cmd_payload_inputs_0  input  32  write data
- cmd_payload_inputs_1  input  32  bits [15:14] bank, [13:0] address, or count; [31:16] ignored
- rsp_valid  output  1  response present; held until rsp_ready
- rsp_ready  input  1  response consumed
- rsp_payload_outputs_0  output  32  response word
- port0..3_addr  output  ADDR_W each  write address, identical on all banks
- port0..3_dout  output  DATA_W each  write data, identical on all banks
- port0..3_wen  output  1 each  write strobe; at most one high per cycle

## Operation

- State: 16-bit ptr = {bank[1:0], addr[13:0]}; 16-bit saturating write counter wcnt; FSM IDLE / FILL / RESP.
- Ops on function_id[2:0]:
  - 0 WRITE: one write to bank=inputs_1[15:14], addr=inputs_1[13:0], data=inputs_0. Response is inputs_1[15:0], zero-extended.
  - 1 SET_PTR: ptr <= inputs_1[15:0]. No write. Response is the old ptr.
  - 2 STREAM: write inputs_0 at ptr, then ptr <= ptr+1. Response is the new ptr.
  - 3 FILL: write inputs_0 to N = inputs_1[15:0] consecutive locations from ptr, one per cycle. ptr advances by N. Response is N.
  - 4 STATUS: no write. Response is {wcnt, ptr}.
  - 5–7: no write. Response is 0.
- ptr arithmetic is 16-bit modulo. The address carries into the bank field: 0x3FFF+1 goes to bank+1, addr 0. 0xFFFF+1 wraps to 0x0000.
- wcnt increments on every wen cycle and saturates at 0xFFFF.
- Transitions:
  - IDLE: on accept, go to FILL if op=FILL and N≥1, otherwise go to RESP.
  - FILL: after the N-th write, go to RESP.
  - RESP: on rsp_ready, go to IDLE. If a new command is accepted in the same cycle, take the IDLE accept transition directly.
- Reset: state IDLE, ptr 0, wcnt 0. All wen 0, all addr/dout 0, rsp_valid 0, rsp_payload 0. A reset during FILL aborts it and no further writes occur.

## Timing

- cmd_ready = (state==IDLE) || (state==RESP && rsp_ready). This is combinational and gives one command per cycle when rsp_ready is held high.
- Port outputs are registered. For a command accepted at cycle T:
  - WRITE/STREAM: write strobe at T+1; rsp_valid rises at T+1.
  - FILL, N≥1: strobes at T+1..T+N; rsp_valid rises at T+N+1.
  - FILL with N=0, and all non-writing ops: rsp_valid rises at T+1, no strobe.
- rsp_valid and rsp_payload stay stable until rsp_ready. No writes occur while waiting in RESP.
- wen is a single-cycle pulse per write. addr/dout hold their last value when wen=0.
- STATUS issued right after a write reflects that write; wcnt is updated at the strobe cycle.

## Structure

- Package cfu_bank_pkg holds:
  - op constants OP_WRITE..OP_STATUS;
  - the FSM state enum;
  - ADDR_W and BANK_W=2 localparams;
  - the NUM_BANKS=4 constant.
- Sub-module bank_wr_decode: registered addr/dout and one-hot wen decode from {valid, bank, addr, data}, fanned out to the four ports.
- The top level holds the FSM, ptr, fill counter, wcnt and the response register.

## Test plan

- Reset low then released: all wen 0, rsp_valid 0, cmd_ready 1. STATUS returns 0x00000000.
- WRITE data 0xDEADBEEF, inputs_1 0x8005: at T+1 port2_wen=1, addr 0x0005, dout 0xDEADBEEF, other wen 0. rsp_valid at T+1 with 0x00008005.
- SET_PTR 0x3FFE, then three back-to-back STREAMs with rsp_ready=1: writes bank0 0x3FFE, bank0 0x3FFF, bank1 0x0000 on consecutive cycles. Responses 0x3FFF, 0x4000, 0x4001.
- SET_PTR 0xFFFE, then FILL N=5 with data 0xA5:
  - writes bank3 0x3FFE, 0x3FFF, then bank0 0x0000–0x0002 at T+1..T+5;
  - rsp_valid at T+6 with value 5;
  - a following STATUS returns {wcnt, 0x0003}.
- FILL N=0: no wen, rsp at T+1 with value 0. Then hold rsp_ready low for 4 cycles: rsp_valid and payload stay stable, cmd_ready 0, no strobes.
- Assert reset at the 3rd strobe of FILL N=100: wen goes 0 immediately. After release, no strobes occur and STATUS returns 0x00000000.
